booth_entry_sequencer: RTL and testbench
========================================

Name: booth_entry_sequencer

Overview:
- Top-level keypad-entry controller for the Booth multiplier calculator.
- Turns debounced keypad events into the operand-storage enables (A, operator, B).
- Starts the Booth multiplier, waits for its completion, and selects what the 7-segment display shows.
- Sits between the keypad scanner/debouncer, the operand storage register block, and the multiplier core.

Parameters:
- MAX_DIGITS, 3, max decimal digits accepted per operand; extra digits ignored.
- SIGN_HOLD, 2, cycles spent in S_SIGN so operand storage sees enable_sign during its delayed load pulse; must be >=2.
- WAIT_TIMEOUT, 64, max cycles in S_WAIT before declaring error.
- RESULT_HOLD, 50000000, cycles result is shown before auto-return (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- key_pressed  in  1  debounced key level
- key_value  in  4  key code: 0-9 digit, A '*', B '+', C '-', D '=', E clear, F unused
- mult_done  in  1  one-cycle pulse from multiplier when product valid
- is_sign_key  out  3  combinational decode of key_value: digit 000, '*' 001, '+' 010, '-' 100, other 111
- enable_A  out  1  operand A entry active
- enable_sign  out  1  operator phase active
- enable_B  out  1  operand B entry active
- neg_A  out  1  operand A negative
- neg_B  out  1  operand B negative
- mult_start  out  1  one-cycle start pulse to multiplier
- display_sel  out  2  00 entry value, 10 product, 11 error pattern
- digit_count  out  2  digits accepted for current operand
- key_ignored  out  1  one-cycle pulse: key event discarded
- error  out  1  high in S_ERR
- state  out  3  current state encoding, for debug/LEDs

Behaviour:
- Clock and reset:
  - All registers update on posedge clk.
  - rst=0 at an edge forces: state=S_A, digit_count=0, neg_A=neg_B=0, counters=0, key_pressed_q=0.
  - Reset mid-operation (including S_WAIT) aborts immediately; a later mult_done is ignored.
- Output decode: enables, display_sel and error decode combinationally from the state register. Reset values are therefore:
  - enable_A=1, enable_sign=0, enable_B=0
  - mult_start=0, key_ignored=0, error=0, display_sel=00
- Key event:
  - key_event = key_pressed & ~key_pressed_q; key_pressed_q is registered.
  - Exactly one event per press; a held key produces no repeats.
- States: S_A=000, S_SIGN=001, S_B=010, S_START=011, S_WAIT=100, S_RESULT=101, S_ERR=110.
- Clear key (E): from any state, the next state is S_A with counters, neg flags and digit_count zeroed. Clear has highest priority.
- S_A:
  - Digit with digit_count<MAX_DIGITS: digit_count+1.
  - Digit with digit_count==MAX_DIGITS: key_ignored pulse, count unchanged.
  - '-' with digit_count==0: neg_A=1. '+' with digit_count==0: neg_A=0. Either key with count>0: key_ignored.
  - '*' with count>0: go to S_SIGN, digit_count=0. '*' with count==0: key_ignored.
  - '=': key_ignored.
- S_SIGN:
  - Counts SIGN_HOLD cycles, then goes to S_B. Keys other than clear are ignored with key_ignored.
- S_B:
  - Digit and +/- rules as in S_A, applied to neg_B.
  - '=' with count>0: go to S_START. '=' with count==0, or '*': key_ignored.
- S_START:
  - mult_start=1 for exactly one cycle, then S_WAIT; watchdog cleared.
- S_WAIT:
  - mult_done: go to S_RESULT.
  - Otherwise watchdog+1; reaching WAIT_TIMEOUT goes to S_ERR.
  - mult_done and timeout in the same cycle: done wins.
  - Non-clear keys: key_ignored.
- S_RESULT: display_sel=10; holds until the clear key. Other keys: key_ignored.
- S_ERR: error=1, display_sel=11; only clear or reset exits.
- Width rules:
  - digit_count saturates at MAX_DIGITS and never wraps.
  - Watchdog width is clog2(WAIT_TIMEOUT+1).
  - A mult_done outside S_WAIT is ignored.

Optional Feature:
- Macro: BOOTH_RESULT_TIMEOUT_EN.
- Defined: S_RESULT increments a hold counter. At RESULT_HOLD it returns to S_A as if clear were pressed. A digit key in S_RESULT also returns to S_A and is consumed (not counted).
- Undefined: S_RESULT holds until clear; no hold counter is synthesized.

Test Plan:
- Reset then keys 1,2,'*',3,'=' with mult_done 5 cycles after start:
  - enable_A until '*'; enable_sign for 2 cycles; enable_B until '='.
  - One mult_start pulse; display_sel=10; state=101.
- Keys '-',7,'*','-',4,'=': neg_A=1 and neg_B=1 at mult_start.
- Keys 9,9,9,9 in S_A: digit_count=3; key_ignored pulses once, on the 4th key.
- Key '*' with no digit, and '=' with an empty B: key_ignored pulse, state unchanged.
- Start and withhold mult_done for 64 cycles: state=110, error=1, display_sel=11; clear returns to S_A. A late mult_done is ignored.
- Clear asserted in S_WAIT in the same cycle as mult_done: state=S_A; also rst=0 held for one edge in S_B gives state=000 with all counters 0.

Source files
------------

// File: rtl/booth_entry_sequencer.sv
// booth_entry_sequencer: keypad-entry controller for the Booth multiplier
// calculator. Converts debounced key events into operand-storage enables,
// starts the multiplier, watches for its completion and selects the display.
// Optional build macro: BOOTH_RESULT_TIMEOUT_EN adds an auto-return from the
// result screen after RESULT_HOLD cycles (or on any digit key).
module booth_entry_sequencer #(
  parameter int MAX_DIGITS   = 3,
  parameter int SIGN_HOLD    = 2,
  parameter int WAIT_TIMEOUT = 64,
  parameter int RESULT_HOLD  = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [3:0] key_value,
  input  logic       mult_done,
  output logic [2:0] is_sign_key,
  output logic       enable_A,
  output logic       enable_sign,
  output logic       enable_B,
  output logic       neg_A,
  output logic       neg_B,
  output logic       mult_start,
  output logic [1:0] display_sel,
  output logic [1:0] digit_count,
  output logic       key_ignored,
  output logic       error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_A      = 3'b000,
    S_SIGN   = 3'b001,
    S_B      = 3'b010,
    S_START  = 3'b011,
    S_WAIT   = 3'b100,
    S_RESULT = 3'b101,
    S_ERR    = 3'b110
  } state_t;

  localparam logic [3:0] K_MUL   = 4'hA;
  localparam logic [3:0] K_PLUS  = 4'hB;
  localparam logic [3:0] K_MINUS = 4'hC;
  localparam logic [3:0] K_EQ    = 4'hD;
  localparam logic [3:0] K_CLEAR = 4'hE;

  localparam int SIGN_W = $clog2(SIGN_HOLD + 1);
  localparam int WD_W   = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [1:0]        DIGIT_MAX = 2'(MAX_DIGITS);
  localparam logic [SIGN_W-1:0] SIGN_LAST = SIGN_W'(SIGN_HOLD - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(WAIT_TIMEOUT);

  // Elaboration-time sanity check on the parameter set.
  if (SIGN_HOLD < 2 || MAX_DIGITS < 1 || MAX_DIGITS > 3 || RESULT_HOLD < 1)
  begin : g_param_check
    $error("booth_entry_sequencer: illegal parameter combination");
  end

  state_t            state_q, state_d;
  logic [1:0]        digit_q, digit_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic [SIGN_W-1:0] sign_q, sign_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WD_W-1:0]   wd_inc;
  logic              key_pressed_q;
  logic              ign_q, ign_d;
  logic              key_event;
  logic              is_digit;

`ifdef BOOTH_RESULT_TIMEOUT_EN
  localparam int HOLD_W = $clog2(RESULT_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(RESULT_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  assign hold_inc = hold_q + 1'b1;
`endif

  assign key_event = key_pressed & ~key_pressed_q;
  assign is_digit  = (key_value <= 4'd9);
  assign wd_inc    = wd_q + 1'b1;

  // Key-code classification for the operand storage block.
  always_comb begin
    if (is_digit)                  is_sign_key = 3'b000;
    else if (key_value == K_MUL)   is_sign_key = 3'b001;
    else if (key_value == K_PLUS)  is_sign_key = 3'b010;
    else if (key_value == K_MINUS) is_sign_key = 3'b100;
    else                           is_sign_key = 3'b111;
  end

  // Next-state and counter logic; clear key overrides every state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    digit_d = digit_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    sign_d  = sign_q;
    wd_d    = wd_q;
    ign_d   = 1'b0;
`ifdef BOOTH_RESULT_TIMEOUT_EN
    hold_d  = hold_q;
`endif
    if (key_event && key_value == K_CLEAR) begin
      state_d = S_A;
      digit_d = '0;
      neg_a_d = 1'b0;
      neg_b_d = 1'b0;
      sign_d  = '0;
      wd_d    = '0;
`ifdef BOOTH_RESULT_TIMEOUT_EN
      hold_d  = '0;
`endif
    end else begin
      unique case (state_q)
        S_A, S_B: begin
          if (key_event) begin
            if (is_digit) begin
              if (digit_q < DIGIT_MAX) digit_d = digit_q + 1'b1;
              else                     ign_d   = 1'b1;
            end else if (key_value == K_PLUS || key_value == K_MINUS) begin
              if (digit_q != 2'd0) ign_d = 1'b1;
              else if (state_q == S_A) neg_a_d = (key_value == K_MINUS);
              else                     neg_b_d = (key_value == K_MINUS);
            end else if (state_q == S_A && key_value == K_MUL && digit_q != 2'd0) begin
              state_d = S_SIGN;
              digit_d = '0;
              sign_d  = '0;
            end else if (state_q == S_B && key_value == K_EQ && digit_q != 2'd0) begin
              state_d = S_START;
            end else begin
              ign_d = 1'b1;
            end
          end
        end
        S_SIGN: begin
          ign_d = key_event;
          if (sign_q == SIGN_LAST) begin
            state_d = S_B;
            sign_d  = '0;
          end else begin
            sign_d = sign_q + 1'b1;
          end
        end
        S_START: begin
          ign_d   = key_event;
          wd_d    = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          ign_d = key_event;
          if (mult_done) begin
            state_d = S_RESULT;
`ifdef BOOTH_RESULT_TIMEOUT_EN
            hold_d  = '0;
`endif
          end else begin
            wd_d = wd_inc;
            if (wd_inc == WD_LIMIT) state_d = S_ERR;
          end
        end
        S_RESULT: begin
`ifdef BOOTH_RESULT_TIMEOUT_EN
          if ((key_event && is_digit) || hold_inc == HOLD_LIMIT) begin
            state_d = S_A;
            digit_d = '0;
            neg_a_d = 1'b0;
            neg_b_d = 1'b0;
            sign_d  = '0;
            wd_d    = '0;
            hold_d  = '0;
          end else begin
            ign_d  = key_event;
            hold_d = hold_inc;
          end
`else
          ign_d = key_event;
`endif
        end
        S_ERR:   ign_d   = key_event;
        default: state_d = S_A;
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      state_q       <= S_A;
      digit_q       <= '0;
      neg_a_q       <= 1'b0;
      neg_b_q       <= 1'b0;
      sign_q        <= '0;
      wd_q          <= '0;
      key_pressed_q <= 1'b0;
      ign_q         <= 1'b0;
`ifdef BOOTH_RESULT_TIMEOUT_EN
      hold_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      digit_q       <= digit_d;
      neg_a_q       <= neg_a_d;
      neg_b_q       <= neg_b_d;
      sign_q        <= sign_d;
      wd_q          <= wd_d;
      key_pressed_q <= key_pressed;
      ign_q         <= ign_d;
`ifdef BOOTH_RESULT_TIMEOUT_EN
      hold_q        <= hold_d;
`endif
    end
  end

  assign enable_A    = (state_q == S_A);
  assign enable_sign = (state_q == S_SIGN);
  assign enable_B    = (state_q == S_B);
  assign mult_start  = (state_q == S_START);
  assign error       = (state_q == S_ERR);
  assign display_sel = (state_q == S_RESULT) ? 2'b10 :
                       (state_q == S_ERR)    ? 2'b11 : 2'b00;
  assign neg_A       = neg_a_q;
  assign neg_B       = neg_b_q;
  assign digit_count = digit_q;
  assign key_ignored = ign_q;
  assign state       = state_q;

endmodule

// File: tb/tb_booth_entry_sequencer.sv
// Self-checking bench for booth_entry_sequencer: directed steps from the test
// plan followed by random key/done traffic, all checked every cycle against a
// key-event interpreter that keeps operands as digit queues.
module tb_booth_entry_sequencer;

  localparam int MAXD        = 3;
  localparam int SIGN_HOLD   = 2;
  localparam int WAIT_TO     = 64;
  localparam int RESULT_HOLD = 50000000;

  localparam int ST_A = 0, ST_SIGN = 1, ST_B = 2, ST_START = 3,
                 ST_WAIT = 4, ST_RESULT = 5, ST_ERR = 6;

  logic       clk = 1'b0;
  logic       rst, key_pressed, mult_done;
  logic [3:0] key_value;
  logic [2:0] is_sign_key, state;
  logic       enable_A, enable_sign, enable_B, neg_A, neg_B;
  logic       mult_start, key_ignored, error;
  logic [1:0] display_sel, digit_count;

  booth_entry_sequencer #(
    .MAX_DIGITS(MAXD), .SIGN_HOLD(SIGN_HOLD),
    .WAIT_TIMEOUT(WAIT_TO), .RESULT_HOLD(RESULT_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .key_pressed(key_pressed), .key_value(key_value),
    .mult_done(mult_done), .is_sign_key(is_sign_key), .enable_A(enable_A),
    .enable_sign(enable_sign), .enable_B(enable_B), .neg_A(neg_A), .neg_B(neg_B),
    .mult_start(mult_start), .display_sel(display_sel), .digit_count(digit_count),
    .key_ignored(key_ignored), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int start_pulses = 0;

  // Reference model: operand digits held in queues, timers as plain counts.
  int m_st = ST_A;
  int opa[$];
  int opb[$];
  bit m_neg_a = 0, m_neg_b = 0, m_prev = 0, m_ign = 0;
  int m_timer = 0;
  int m_hold = 0;

  task automatic model_clear();
    m_st = ST_A;
    opa.delete();
    opb.delete();
    m_neg_a = 0;
    m_neg_b = 0;
    m_timer = 0;
    m_hold  = 0;
  endtask

  task automatic model_edge(input bit r, input bit kp, input logic [3:0] kv, input bit md);
    bit ev;
    int cnt;
    if (!r) begin
      model_clear();
      m_prev = 0;
      m_ign  = 0;
      return;
    end
    ev = kp && !m_prev;
    m_prev = kp;
    m_ign = 0;
    if (ev && kv == 4'hE) begin
      model_clear();
      return;
    end
    case (m_st)
      ST_A, ST_B: if (ev) begin
        cnt = (m_st == ST_A) ? opa.size() : opb.size();
        if (kv <= 4'd9) begin
          if (cnt < MAXD) begin
            if (m_st == ST_A) opa.push_back(int'(kv));
            else              opb.push_back(int'(kv));
          end else m_ign = 1;
        end else if (kv == 4'hB || kv == 4'hC) begin
          if (cnt != 0) m_ign = 1;
          else if (m_st == ST_A) m_neg_a = (kv == 4'hC);
          else                   m_neg_b = (kv == 4'hC);
        end else if (m_st == ST_A && kv == 4'hA && cnt > 0) begin
          m_st = ST_SIGN;
          m_timer = 0;
        end else if (m_st == ST_B && kv == 4'hD && cnt > 0) begin
          m_st = ST_START;
        end else m_ign = 1;
      end
      ST_SIGN: begin
        m_ign = ev;
        m_timer++;
        if (m_timer == SIGN_HOLD) begin
          m_st = ST_B;
          m_timer = 0;
        end
      end
      ST_START: begin
        m_ign = ev;
        m_st = ST_WAIT;
        m_timer = 0;
      end
      ST_WAIT: begin
        m_ign = ev;
        if (md) begin
          m_st = ST_RESULT;
          m_hold = 0;
        end else begin
          m_timer++;
          if (m_timer == WAIT_TO) m_st = ST_ERR;
        end
      end
      ST_RESULT: begin
`ifdef BOOTH_RESULT_TIMEOUT_EN
        if (ev && kv <= 4'd9) model_clear();
        else begin
          m_ign = ev;
          m_hold++;
          if (m_hold == RESULT_HOLD) model_clear();
        end
`else
        m_ign = ev;
`endif
      end
      default: m_ign = ev;
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2:0] exp_sign;
    if (key_value <= 4'd9)       exp_sign = 3'b000;
    else if (key_value == 4'hA)  exp_sign = 3'b001;
    else if (key_value == 4'hB)  exp_sign = 3'b010;
    else if (key_value == 4'hC)  exp_sign = 3'b100;
    else                         exp_sign = 3'b111;
    check("state", 32'(state), 32'(m_st));
    check("enable_A", 32'(enable_A), 32'(m_st == ST_A));
    check("enable_sign", 32'(enable_sign), 32'(m_st == ST_SIGN));
    check("enable_B", 32'(enable_B), 32'(m_st == ST_B));
    check("mult_start", 32'(mult_start), 32'(m_st == ST_START));
    check("error", 32'(error), 32'(m_st == ST_ERR));
    check("display_sel", 32'(display_sel),
          (m_st == ST_RESULT) ? 32'd2 : (m_st == ST_ERR) ? 32'd3 : 32'd0);
    check("neg_A", 32'(neg_A), 32'(m_neg_a));
    check("neg_B", 32'(neg_B), 32'(m_neg_b));
    check("digit_count", 32'(digit_count),
          (m_st == ST_A) ? 32'(opa.size()) : 32'(opb.size()));
    check("key_ignored", 32'(key_ignored), 32'(m_ign));
    check("is_sign_key", 32'(is_sign_key), 32'(exp_sign));
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, compare 1 ns later.
  task automatic step(input bit r, input bit kp, input logic [3:0] kv, input bit md);
    @(negedge clk);
    rst = r;
    key_pressed = kp;
    key_value = kv;
    mult_done = md;
    @(posedge clk);
    model_edge(r, kp, kv, md);
    #1;
    if (mult_start === 1'b1) start_pulses++;
    check_outputs();
  endtask

  task automatic press(input logic [3:0] k);
    step(1, 1, k, 0);
    step(1, 0, k, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 4'h0, 0);
  endtask

  initial begin
    rst = 0;
    key_pressed = 0;
    key_value = 4'h0;
    mult_done = 0;

    // Reset state.
    step(0, 0, 4'h0, 0);
    step(0, 0, 4'h0, 0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_enable_A", 32'(enable_A), 32'd1);
    check("rst_display", 32'(display_sel), 32'd0);

    // 1 2 * 3 = with mult_done five cycles after the start pulse.
    start_pulses = 0;
    press(4'h1);
    press(4'h2);
    press(4'hA);
    idle(2);
    press(4'h3);
    step(1, 1, 4'hD, 0);
    check("flow1_start", 32'(mult_start), 32'd1);
    step(1, 0, 4'hD, 0);
    idle(3);
    step(1, 0, 4'h0, 1);
    idle(2);
    check("flow1_state", 32'(state), 32'h5);
    check("flow1_display", 32'(display_sel), 32'h2);
    check("flow1_start_pulses", 32'(start_pulses), 32'd1);
    press(4'hE);

    // Negative operands: - 7 * - 4 =
    press(4'hC);
    press(4'h7);
    press(4'hA);
    idle(2);
    press(4'hC);
    press(4'h4);
    step(1, 1, 4'hD, 0);
    check("neg_start", 32'(mult_start), 32'd1);
    check("neg_A_at_start", 32'(neg_A), 32'd1);
    check("neg_B_at_start", 32'(neg_B), 32'd1);
    step(1, 0, 4'hD, 0);
    press(4'hE);

    // Digit saturation: 9 9 9 9.
    press(4'h9);
    press(4'h9);
    press(4'h9);
    step(1, 1, 4'h9, 0);
    check("sat_count", 32'(digit_count), 32'd3);
    check("sat_ignored", 32'(key_ignored), 32'd1);
    step(1, 0, 4'h9, 0);
    check("sat_ignored_clears", 32'(key_ignored), 32'd0);
    press(4'hE);

    // '*' with no digit, then '=' with empty B.
    step(1, 1, 4'hA, 0);
    check("empty_mul_ign", 32'(key_ignored), 32'd1);
    check("empty_mul_state", 32'(state), 32'd0);
    step(1, 0, 4'hA, 0);
    press(4'h5);
    press(4'hA);
    idle(2);
    step(1, 1, 4'hD, 0);
    check("empty_eq_ign", 32'(key_ignored), 32'd1);
    check("empty_eq_state", 32'(state), 32'd2);
    step(1, 0, 4'hD, 0);

    // Watchdog: 64 cycles in S_WAIT without mult_done.
    press(4'h6);
    step(1, 1, 4'hD, 0);
    step(1, 0, 4'hD, 0);
    idle(63);
    check("wd_still_wait", 32'(state), 32'h4);
    idle(1);
    check("wd_err_state", 32'(state), 32'h6);
    check("wd_error", 32'(error), 32'd1);
    check("wd_display", 32'(display_sel), 32'h3);
    step(1, 0, 4'h0, 1);
    check("late_done_ignored", 32'(state), 32'h6);
    press(4'hE);
    check("err_clear", 32'(state), 32'd0);

    // Clear in S_WAIT together with mult_done.
    press(4'h1);
    press(4'hA);
    idle(2);
    press(4'h2);
    press(4'hD);
    idle(2);
    step(1, 1, 4'hE, 1);
    check("clear_vs_done", 32'(state), 32'd0);
    step(1, 0, 4'hE, 0);

    // Synchronous reset while in S_B.
    press(4'h3);
    press(4'hA);
    idle(2);
    press(4'hC);
    press(4'h8);
    check("pre_rst_state", 32'(state), 32'd2);
    step(0, 0, 4'h0, 0);
    check("rst_in_b_state", 32'(state), 32'd0);
    check("rst_in_b_count", 32'(digit_count), 32'd0);
    check("rst_in_b_negB", 32'(neg_B), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      logic [3:0] k;
      int hold_len, gap;
      k = 4'($urandom_range(0, 15));
      hold_len = $urandom_range(1, 3);
      gap = $urandom_range(0, 3);
      for (int j = 0; j < hold_len; j++)
        step($urandom_range(0, 199) != 0, 1, k, $urandom_range(0, 7) == 0);
      for (int j = 0; j < gap; j++)
        step(1, 0, k, $urandom_range(0, 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
